// File: rtl/posit_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : posit_seq_pkg
// Brief    : Shared constants, state encoding and sizing helper for the
//            posit memory sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package posit_seq_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTES_PER_PAIR = 8;

    // Sequencer state encoding
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_FETCH = 3'd1;
    localparam logic [2:0] c_ST_ISSUE = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_WRITE = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    // Number of operand pairs that fit in a byte-addressed RAM of 2^addr_w bytes
    function automatic int max_pairs(input int addr_w);
        return (1 << addr_w) / BYTES_PER_PAIR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/posit_mem_sequencer_byte_gather.sv
`default_nettype none
// ============================================================================
// Module   : byte_gather
// Brief    : Tracks in-flight operand RAM reads with a RD_LAT-deep
//            valid/lane pipeline and assembles returned bytes into the
//            little-endian A and B operand words.
// Revision : 1.0 - initial release
// ============================================================================
module byte_gather
    import posit_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int WORD_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_issue,
    input  logic [2:0]        i_lane,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [WORD_W-1:0] o_a,
    output logic [WORD_W-1:0] o_b,
    output logic              o_done
);

    logic [RD_LAT-1:0] r_vld;
    logic [2:0]        r_lane [RD_LAT];
    logic [WORD_W-1:0] r_a;
    logic [WORD_W-1:0] r_b;
    logic              w_cap;
    logic [2:0]        w_cap_lane;
    int                w_cap_lsb;

    // The tail of the pipeline lines up with readdata for that read
    assign w_cap      = r_vld[RD_LAT-1];
    assign w_cap_lane = r_lane[RD_LAT-1];
    assign w_cap_lsb  = int'(w_cap_lane[1:0]) * DATA_W;
    assign o_done     = w_cap && (w_cap_lane == 3'(BYTES_PER_PAIR - 1));
    assign o_a        = r_a;
    assign o_b        = r_b;

    // Delay each issued read's valid flag and lane tag by the RAM read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                r_lane[s] <= '0;
            end
        end else begin
            r_vld[0]  <= i_issue;
            r_lane[0] <= i_lane;
            for (int s = 1; s < RD_LAT; s++) begin
                r_vld[s]  <= r_vld[s-1];
                r_lane[s] <= r_lane[s-1];
            end
        end
    end

    // Drop each returned byte into its lane; lanes 0-3 build A, 4-7 build B
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_cap) begin
            if (!w_cap_lane[2]) begin
                r_a[w_cap_lsb +: DATA_W] <= i_rdata;
            end else begin
                r_b[w_cap_lsb +: DATA_W] <= i_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/posit_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : posit_mem_sequencer
// Brief    : Fetches operand pairs byte-wise from operand RAM, hands each
//            pair to the posit unit, and writes results byte-wise to result
//            RAM, reporting completion to the HPS PIO.
// Revision : 1.0 - initial release
// ============================================================================
module posit_mem_sequencer
    import posit_seq_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int WORD_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              soft_reset,
    input  logic              start,
    input  logic [31:0]       pair_count,
    output logic              completed,
    output logic              busy,
    output logic [ADDR_W-1:0] m0_address,
    output logic              m0_chipselect,
    output logic              m0_clken,
    output logic              m0_write,
    output logic [DATA_W-1:0] m0_writedata,
    input  logic [DATA_W-1:0] m0_readdata,
    output logic [ADDR_W-1:0] m1_address,
    output logic              m1_chipselect,
    output logic              m1_clken,
    output logic              m1_write,
    output logic [DATA_W-1:0] m1_writedata,
    input  logic [DATA_W-1:0] m1_readdata,
    output logic              pu_in_valid,
    input  logic              pu_in_ready,
    output logic [WORD_W-1:0] pu_num1,
    output logic [WORD_W-1:0] pu_num2,
    input  logic              pu_out_valid,
    input  logic [WORD_W-1:0] pu_result
);

    localparam int C_IDX_W     = ADDR_W - 2;
    localparam int C_MAX_PAIRS = max_pairs(ADDR_W);

    logic               w_rst;
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               r_start;
    logic [C_IDX_W-1:0] r_count;
    logic [C_IDX_W-1:0] w_count_nxt;
    logic [C_IDX_W-1:0] r_idx;
    logic [C_IDX_W-1:0] w_idx_nxt;
    logic [C_IDX_W-1:0] w_idx_inc;
    logic [C_IDX_W-1:0] w_sat_count;
    logic [3:0]         r_k;
    logic [3:0]         w_k_nxt;
    logic [WORD_W-1:0]  r_result;
    logic [WORD_W-1:0]  w_result_nxt;
    logic               w_start_edge;
    logic               w_issue;
    logic               w_wr;
    logic               w_gather_done;
    logic               w_unused;

    assign w_rst        = !reset_reset_n || soft_reset;
    assign w_start_edge = start && !r_start;
    assign w_idx_inc    = r_idx + C_IDX_W'(1);
    assign w_sat_count  = (pair_count > 32'(C_MAX_PAIRS)) ? C_IDX_W'(C_MAX_PAIRS)
                                                          : pair_count[C_IDX_W-1:0];

    // r_k counts byte reads in FETCH (bit 3 set once all 8 are issued) and bytes in WRITE
    assign w_issue = (r_state == c_ST_FETCH) && !r_k[3];
    assign w_wr    = (r_state == c_ST_WRITE);

    assign completed     = (r_state == c_ST_DONE);
    assign busy          = (r_state == c_ST_FETCH) || (r_state == c_ST_ISSUE) ||
                           (r_state == c_ST_WAIT)  || (r_state == c_ST_WRITE);
    assign m0_chipselect = w_issue;
    assign m0_clken      = w_issue;
    assign m0_write      = 1'b0;
    assign m0_writedata  = '0;
    assign m0_address    = w_issue ? {r_idx[C_IDX_W-2:0], r_k[2:0]} : '0;
    assign m1_chipselect = w_wr;
    assign m1_clken      = w_wr;
    assign m1_write      = w_wr;
    assign m1_address    = w_wr ? {r_idx, r_k[1:0]} : '0;
    assign m1_writedata  = w_wr ? r_result[int'(r_k[1:0]) * DATA_W +: DATA_W] : '0;
    assign pu_in_valid   = (r_state == c_ST_ISSUE);
    assign w_unused      = ^m1_readdata;

    byte_gather #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W),
        .RD_LAT (RD_LAT)
    ) u_gather (
        .clk     (clk_clk),
        .rst     (w_rst),
        .i_issue (w_issue),
        .i_lane  (r_k[2:0]),
        .i_rdata (m0_readdata),
        .o_a     (pu_num1),
        .o_b     (pu_num2),
        .o_done  (w_gather_done)
    );

    // Sequencer next-state: fetch, hand off, wait, write back, repeat per pair
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_idx_nxt    = r_idx;
        w_k_nxt      = r_k;
        w_result_nxt = r_result;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_edge) begin
                    w_count_nxt = w_sat_count;
                    w_idx_nxt   = '0;
                    w_k_nxt     = '0;
                    w_state_nxt = (w_sat_count == '0) ? c_ST_DONE : c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                if (!r_k[3]) begin
                    w_k_nxt = r_k + 4'd1;
                end
                if (w_gather_done) begin
                    w_k_nxt     = '0;
                    w_state_nxt = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                if (pu_in_ready) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (pu_out_valid) begin
                    w_result_nxt = pu_result;
                    w_k_nxt      = '0;
                    w_state_nxt  = c_ST_WRITE;
                end
            end
            c_ST_WRITE: begin
                w_k_nxt = r_k + 4'd1;
                if (r_k == 4'(BYTES_PER_WORD - 1)) begin
                    w_k_nxt     = '0;
                    w_idx_nxt   = w_idx_inc;
                    w_state_nxt = (w_idx_inc == r_count) ? c_ST_DONE : c_ST_FETCH;
                end
            end
            c_ST_DONE: begin
                if (!start) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State registers; either reset source abandons any run in progress
    always_ff @(posedge clk_clk) begin
        if (w_rst) begin
            r_state  <= c_ST_IDLE;
            r_start  <= 1'b0;
            r_count  <= '0;
            r_idx    <= '0;
            r_k      <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_start  <= start;
            r_count  <= w_count_nxt;
            r_idx    <= w_idx_nxt;
            r_k      <= w_k_nxt;
            r_result <= w_result_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_posit_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_posit_mem_sequencer
// Brief    : Directed scoreboard bench for posit_mem_sequencer with RAM and
//            posit-unit models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_posit_mem_sequencer;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int WORD_W = 32;
    localparam int RD_LAT = 1;

    logic              clk_clk = 1'b0;
    logic              reset_reset_n;
    logic              soft_reset;
    logic              start;
    logic [31:0]       pair_count;
    logic              completed;
    logic              busy;
    logic [ADDR_W-1:0] m0_address;
    logic              m0_chipselect;
    logic              m0_clken;
    logic              m0_write;
    logic [DATA_W-1:0] m0_writedata;
    logic [DATA_W-1:0] m0_readdata = '0;
    logic [ADDR_W-1:0] m1_address;
    logic              m1_chipselect;
    logic              m1_clken;
    logic              m1_write;
    logic [DATA_W-1:0] m1_writedata;
    logic [DATA_W-1:0] m1_readdata;
    logic              pu_in_valid;
    logic              pu_in_ready;
    logic [WORD_W-1:0] pu_num1;
    logic [WORD_W-1:0] pu_num2;
    logic              pu_out_valid = 1'b0;
    logic [WORD_W-1:0] pu_result = '0;

    always #5 clk_clk = ~clk_clk;

    posit_mem_sequencer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .WORD_W (WORD_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .soft_reset    (soft_reset),
        .start         (start),
        .pair_count    (pair_count),
        .completed     (completed),
        .busy          (busy),
        .m0_address    (m0_address),
        .m0_chipselect (m0_chipselect),
        .m0_clken      (m0_clken),
        .m0_write      (m0_write),
        .m0_writedata  (m0_writedata),
        .m0_readdata   (m0_readdata),
        .m1_address    (m1_address),
        .m1_chipselect (m1_chipselect),
        .m1_clken      (m1_clken),
        .m1_write      (m1_write),
        .m1_writedata  (m1_writedata),
        .m1_readdata   (m1_readdata),
        .pu_in_valid   (pu_in_valid),
        .pu_in_ready   (pu_in_ready),
        .pu_num1       (pu_num1),
        .pu_num2       (pu_num2),
        .pu_out_valid  (pu_out_valid),
        .pu_result     (pu_result)
    );

    assign m1_readdata = '0;

    logic [7:0]  mem0 [4096];
    int          vectors = 0;
    int          miscompares = 0;
    logic [19:0] sb [$];

    // Observation logs, written only by the monitor
    int          m0_acc = 0;
    int          wr_total = 0;
    logic [11:0] wr_addr [4096];
    logic [7:0]  wr_data [4096];
    int          st_n = 0;
    logic [31:0] st_a [16];
    logic [31:0] st_b [16];
    int          wr_rd = 0;

    // PU model controls, written only by the stimulus block
    int pu_lat = 1;
    int stall_pair = -1;
    int stall_n = 0;
    // PU model state, written only by the PU model
    int          hs_cnt = 0;
    int          stall_cnt = 0;
    logic        pend = 1'b0;
    int          lat_cnt = 0;
    logic [31:0] pu_hold = '0;

    // Posit-unit stand-in: posit(es=2) 0x40000000 + 0x40000000 = 0x48000000, integer add otherwise
    function automatic logic [31:0] pu_func(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4800_0000;
        return a + b;
    endfunction

    function automatic logic [31:0] opw(input int base);
        return {mem0[base+3], mem0[base+2], mem0[base+1], mem0[base]};
    endfunction

    // Operand RAM, read latency 1
    always @(posedge clk_clk) begin
        if (m0_chipselect && m0_clken && !m0_write) m0_readdata <= mem0[m0_address];
    end

    assign pu_in_ready = !((hs_cnt == stall_pair) && (stall_cnt < stall_n));

    // Posit unit with configurable latency and single-cycle result strobe
    always @(posedge clk_clk) begin
        pu_out_valid <= 1'b0;
        if (pu_in_valid && !pu_in_ready) stall_cnt <= stall_cnt + 1;
        if (pu_in_valid && pu_in_ready) begin
            hs_cnt  <= hs_cnt + 1;
            pend    <= 1'b1;
            lat_cnt <= pu_lat;
            pu_hold <= pu_func(pu_num1, pu_num2);
        end else if (pend) begin
            if (lat_cnt <= 1) begin
                pend         <= 1'b0;
                pu_out_valid <= 1'b1;
                pu_result    <= pu_hold;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    // Bus monitor
    always @(negedge clk_clk) begin
        if (m0_chipselect) m0_acc++;
        if (m1_write && m1_chipselect && m1_clken && wr_total < 4096) begin
            wr_addr[wr_total] = m1_address;
            wr_data[wr_total] = m1_writedata;
            wr_total++;
        end
        if (pu_in_valid && !pu_in_ready && st_n < 16) begin
            st_a[st_n] = pu_num1;
            st_b[st_n] = pu_num2;
            st_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pair(input int i);
        logic [31:0] r;
        r = pu_func(opw(8*i), opw(8*i + 4));
        for (int k = 0; k < 4; k++) sb.push_back({12'(4*i + k), r[8*k +: 8]});
    endtask

    // Compare every logged result write against the scoreboard, then require it empty
    task automatic drain(input string tag);
        logic [19:0] e;
        while (wr_rd < wr_total) begin
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL %s_extra_write: observed addr %0h data %0h expected none",
                       tag, wr_addr[wr_rd], wr_data[wr_rd]);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({tag, "_wr"}, {12'h0, wr_addr[wr_rd], wr_data[wr_rd]}, {12'h0, e});
            end
            wr_rd++;
        end
        chk({tag, "_sb_left"}, sb.size(), 0);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while (!completed && n < budget) begin
            @(negedge clk_clk);
            n++;
        end
        chk({tag, "_completed"}, 32'(completed), 32'd1);
    endtask

    task automatic finish_run(input string tag);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        start = 1'b0;
        @(negedge clk_clk);
        chk({tag, "_completed_clear"}, 32'(completed), 32'd0);
    endtask

    initial begin
        int wr_base;
        int m0_base;
        int n;
        reset_reset_n = 1'b0;
        soft_reset    = 1'b0;
        start         = 1'b0;
        pair_count    = '0;
        for (int i = 0; i < 4096; i++) mem0[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) mem0[i] = ((i % 4) == 3) ? 8'h40 : 8'h00;

        repeat (3) @(negedge clk_clk);
        chk("rst_completed", 32'(completed), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_m0_cs", {29'h0, m0_chipselect, m0_clken, m0_write}, 0);
        chk("rst_m1_cs", {29'h0, m1_chipselect, m1_clken, m1_write}, 0);
        chk("rst_addr", {8'h0, m0_address, m1_address}, 0);
        chk("rst_pu_valid", 32'(pu_in_valid), 0);
        chk("rst_num1", pu_num1, 0);
        chk("rst_num2", pu_num2, 0);
        chk("rst_m0_wdata", 32'(m0_writedata), 0);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);

        // 1: single pair, 1.0 + 1.0
        sb.push_back({12'h000, 8'h00});
        sb.push_back({12'h001, 8'h00});
        sb.push_back({12'h002, 8'h00});
        sb.push_back({12'h003, 8'h48});
        wr_base = wr_total;
        pair_count = 1;
        start = 1'b1;
        wait_done(200, "t1");
        chk("t1_nwr", wr_total - wr_base, 4);
        drain("t1");
        finish_run("t1");

        // 2: three pairs, PU latency 5, ready held low 3 cycles on pair 1
        pu_lat     = 5;
        stall_pair = hs_cnt + 1;
        stall_n    = 3;
        for (int i = 0; i < 3; i++) push_pair(i);
        wr_base = wr_total;
        pair_count = 3;
        start = 1'b1;
        wait_done(500, "t2");
        chk("t2_nwr", wr_total - wr_base, 12);
        chk("t2_stall_cycles", st_n, 3);
        for (int s = 0; s < 3 && s < st_n; s++) begin
            chk("t2_stall_a", st_a[s], opw(8));
            chk("t2_stall_b", st_b[s], opw(12));
        end
        drain("t2");
        finish_run("t2");

        // 3: zero pairs
        pu_lat = 1;
        wr_base = wr_total;
        m0_base = m0_acc;
        pair_count = 0;
        start = 1'b1;
        n = 0;
        while (!completed && n < 2) begin
            @(negedge clk_clk);
            n++;
        end
        chk("t3_completed", 32'(completed), 1);
        chk("t3_m0_acc", m0_acc - m0_base, 0);
        chk("t3_m1_wr", wr_total - wr_base, 0);
        finish_run("t3");

        // 4: oversized count saturates at 512 pairs
        for (int i = 0; i < 512; i++) push_pair(i);
        wr_base = wr_total;
        pair_count = 1000;
        start = 1'b1;
        wait_done(20000, "t4");
        chk("t4_nwr", wr_total - wr_base, 2048);
        chk("t4_last_addr", {20'h0, wr_addr[(wr_total > 0) ? wr_total - 1 : 0]}, 32'h7FF);
        drain("t4");
        finish_run("t4");

        // 5: start toggled mid-run is ignored
        for (int i = 0; i < 2; i++) push_pair(i);
        wr_base = wr_total;
        pair_count = 2;
        start = 1'b1;
        repeat (10) @(negedge clk_clk);
        start = 1'b0;
        repeat (2) @(negedge clk_clk);
        chk("t5_busy_mid", 32'(busy), 1);
        start = 1'b1;
        wait_done(300, "t5");
        repeat (3) @(negedge clk_clk);
        chk("t5_completed_hold", 32'(completed), 1);
        chk("t5_nwr", wr_total - wr_base, 8);
        drain("t5");
        finish_run("t5");

        // 6: soft reset during the write-back of pair 2
        for (int i = 0; i < 2; i++) push_pair(i);
        begin
            logic [31:0] r2;
            r2 = pu_func(opw(16), opw(20));
            sb.push_back({12'h008, r2[7:0]});
            sb.push_back({12'h009, r2[15:8]});
        end
        pair_count = 4;
        start = 1'b1;
        n = 0;
        while (!(m1_write && m1_address == 12'h009) && n < 400) begin
            @(negedge clk_clk);
            n++;
        end
        chk("t6_reached_write", {31'h0, m1_write}, 1);
        soft_reset = 1'b1;
        @(negedge clk_clk);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_completed", 32'(completed), 0);
        chk("t6_m1_ctl", {29'h0, m1_chipselect, m1_clken, m1_write}, 0);
        chk("t6_m0_ctl", {30'h0, m0_chipselect, m0_clken}, 0);
        chk("t6_addr", {8'h0, m0_address, m1_address}, 0);
        chk("t6_pu", {31'h0, pu_in_valid}, 0);
        chk("t6_num1", pu_num1, 0);
        chk("t6_num2", pu_num2, 0);
        soft_reset = 1'b0;
        start = 1'b0;
        repeat (30) @(negedge clk_clk);
        chk("t6_idle_busy", 32'(busy), 0);
        drain("t6a");
        push_pair(0);
        wr_base = wr_total;
        pair_count = 1;
        start = 1'b1;
        wait_done(200, "t6b");
        chk("t6b_nwr", wr_total - wr_base, 4);
        drain("t6b");
        finish_run("t6b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
